// File: rtl/drive_ii_pkg.sv
// Shared Disk II ramdisk geometry and address mapping, used by both the read head and the
// track writer so that both sides compute identical SDRAM word addresses.
package drive_ii_pkg;

    localparam int unsigned NUM_TRACKS  = 35;
    localparam int unsigned TRACK_BYTES = 6656;

    localparam logic [5:0]  TRACK_LIMIT  = 6'(NUM_TRACKS);
    localparam logic [12:0] BYTE_LIMIT   = 13'(TRACK_BYTES);
    localparam logic [20:0] RAMDISK_BASE = 21'h02_0000;

    typedef struct packed {
        logic [20:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_entry_t;

    // Linear nibble offset of a byte within the whole ramdisk image of one drive.
    function automatic logic [19:0] track_lin(input logic [5:0] track,
                                              input logic [12:0] byte_addr);
        return 20'(track) * 20'(TRACK_BYTES) + 20'(byte_addr);
    endfunction

    function automatic logic [20:0] ramdisk_word_addr(input logic        drive_id,
                                                      input logic [5:0]  track,
                                                      input logic [12:0] byte_addr);
        logic [19:0] lin;
        lin = track_lin(track, byte_addr);
        return RAMDISK_BASE | {4'b0000, drive_id, lin[17:2]};
    endfunction

endpackage

// File: rtl/drive_ii_wr_fifo.sv
// Synchronous FIFO of pending SDRAM word writes. A push while full is accepted only when a pop
// frees a slot in the same cycle; otherwise it is dropped and the caller flags the loss.
module drive_ii_wr_fifo
    import drive_ii_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk_logic,
    input  logic      system_reset_n,
    input  logic      push,
    input  wr_entry_t push_data,
    input  logic      pop,
    output wr_entry_t pop_data,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    wr_entry_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           push_ok, pop_ok;

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk_logic) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/drive_ii_track_writer.sv
// Disk II write-back path: packs nibble strobes into byte-enabled 32-bit SDRAM words, queues
// them to the memory client port and keeps per-track dirty flags for SD-card write-back.
module drive_ii_track_writer
    import drive_ii_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned FLUSH_TIMEOUT = 64
) (
    input  logic                  clk_logic,
    input  logic                  system_reset_n,
    input  logic                  drive_id_i,
    input  logic                  write_mode_i,
    input  logic                  nib_we_i,
    input  logic [7:0]            nib_data_i,
    input  logic [5:0]            track_i,
    input  logic [12:0]           byte_addr_i,
    output logic                  mem_wr_o,
    output logic [20:0]           mem_addr_o,
    output logic [31:0]           mem_data_o,
    output logic [3:0]            mem_byte_en_o,
    input  logic                  mem_ready_i,
    output logic [NUM_TRACKS-1:0] dirty_o,
    input  logic [NUM_TRACKS-1:0] dirty_clr_i,
    output logic                  busy_o,
    output logic                  overflow_o
);

    localparam int unsigned IW = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(FLUSH_TIMEOUT);

    logic                  acc_valid_q, acc_valid_d;
    logic [20:0]           acc_addr_q, acc_addr_d;
    logic [31:0]           acc_data_q, acc_data_d;
    logic [3:0]            acc_be_q, acc_be_d;
    logic [IW-1:0]         idle_q, idle_d, idle_inc;
    logic                  overflow_q, overflow_d;
    logic [NUM_TRACKS-1:0] dirty_q, dirty_d, dirty_set;

    logic        strobe_ok;
    logic [19:0] strobe_lin;
    logic [1:0]  strobe_lane;
    logic [20:0] strobe_addr;

    logic      push, pop, fifo_full, fifo_empty;
    wr_entry_t push_entry, head;

    assign strobe_ok   = nib_we_i && (track_i < TRACK_LIMIT) && (byte_addr_i < BYTE_LIMIT);
    assign strobe_lin  = track_lin(track_i, byte_addr_i);
    assign strobe_lane = strobe_lin[1:0];
    assign strobe_addr = ramdisk_word_addr(drive_id_i, track_i, byte_addr_i);
    assign idle_inc    = idle_q + 1'b1;

    assign push_entry = '{addr: acc_addr_q, data: acc_data_q, be: acc_be_q};

    always_comb begin
        acc_valid_d = acc_valid_q;
        acc_addr_d  = acc_addr_q;
        acc_data_d  = acc_data_q;
        acc_be_d    = acc_be_q;
        idle_d      = idle_q;
        push        = 1'b0;
        if (strobe_ok) begin
            idle_d = '0;
            if (acc_valid_q && (acc_addr_q == strobe_addr)) begin
                acc_data_d[{strobe_lane, 3'b000} +: 8] = nib_data_i;
                acc_be_d[strobe_lane]                  = 1'b1;
            end else begin
                // A strobe to a different word evicts the current one in the same cycle.
                push                                   = acc_valid_q;
                acc_valid_d                            = 1'b1;
                acc_addr_d                             = strobe_addr;
                acc_data_d                             = '0;
                acc_data_d[{strobe_lane, 3'b000} +: 8] = nib_data_i;
                acc_be_d                               = '0;
                acc_be_d[strobe_lane]                  = 1'b1;
            end
        end else if (acc_valid_q) begin
            // idle_inc counts the current quiet cycle, so the timeout fires on the
            // FLUSH_TIMEOUT-th cycle after the last strobe.
            if ((acc_be_q == 4'b1111) || (idle_inc == IDLE_LIMIT) || !write_mode_i) begin
                push        = 1'b1;
                acc_valid_d = 1'b0;
                idle_d      = '0;
            end else begin
                idle_d = idle_inc;
            end
        end
    end

    always_comb begin
        dirty_set = '0;
        if (strobe_ok) begin
            dirty_set[track_i] = 1'b1;
        end
        dirty_d    = (dirty_q & ~dirty_clr_i) | dirty_set;
        overflow_d = overflow_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            acc_valid_q <= 1'b0;
            acc_addr_q  <= '0;
            acc_data_q  <= '0;
            acc_be_q    <= '0;
            idle_q      <= '0;
            overflow_q  <= 1'b0;
            dirty_q     <= '0;
        end else begin
            acc_valid_q <= acc_valid_d;
            acc_addr_q  <= acc_addr_d;
            acc_data_q  <= acc_data_d;
            acc_be_q    <= acc_be_d;
            idle_q      <= idle_d;
            overflow_q  <= overflow_d;
            dirty_q     <= dirty_d;
        end
    end

    drive_ii_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_logic      (clk_logic),
        .system_reset_n (system_reset_n),
        .push           (push),
        .push_data      (push_entry),
        .pop            (pop),
        .pop_data       (head),
        .full           (fifo_full),
        .empty          (fifo_empty)
    );

    assign pop           = !fifo_empty && mem_ready_i;
    assign mem_wr_o      = !fifo_empty;
    assign mem_addr_o    = fifo_empty ? '0 : head.addr;
    assign mem_data_o    = fifo_empty ? '0 : head.data;
    assign mem_byte_en_o = fifo_empty ? '0 : head.be;
    assign dirty_o       = dirty_q;
    assign busy_o        = acc_valid_q || !fifo_empty;
    assign overflow_o    = overflow_q;

endmodule
